// File: rtl/mem_load_unit_pkg.sv
// Shared encodings for the load unit: mode bit positions,
// size codes, FSM states and the captured request context.
package mem_load_unit_pkg;

  localparam int MODE_LOAD    = 5;
  localparam int MODE_SIZE_HI = 3;
  localparam int MODE_SIZE_LO = 1;
  localparam int MODE_SEXT    = 0;

  localparam logic [2:0] SZ_BYTE = 3'b000;
  localparam logic [2:0] SZ_HALF = 3'b001;
  localparam logic [2:0] SZ_WORD = 3'b010;
  localparam logic [2:0] SZ_LWL  = 3'b011;
  localparam logic [2:0] SZ_LWR  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  typedef struct packed {
    logic [2:0]  size;
    logic        sext;
    logic [1:0]  off;
    logic [31:0] rt;
  } ld_ctx_t;

  function automatic logic misaligned(
    input logic [2:0] size,
    input logic [1:0] off
  );
    return (size == SZ_HALF && off[0]) ||
           (size == SZ_WORD && off != 2'b00);
  endfunction

endpackage

// File: rtl/mem_load_unit_load_align.sv
// Lane select, sign/zero extension and LWL/LWR merge
// of a returned SRAM word.
module load_align
  import mem_load_unit_pkg::*;
(
  input  logic [2:0]  size,
  input  logic        sext,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  input  logic [31:0] rt,
  output logic [31:0] data
);

  logic [4:0]  sh;
  logic [4:0]  lsh;
  logic [7:0]  b;
  logic [15:0] h;

  assign sh  = {addr, 3'b000};
  assign lsh = {~addr, 3'b000};
  assign b   = rdata[sh +: 8];
  assign h   = addr[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = rdata;
    unique case (1'b1)
      size == SZ_BYTE:
        data = {{24{sext & b[7]}}, b};
      size == SZ_HALF:
        data = {{16{sext & h[15]}}, h};
      size == SZ_LWL:
        data = (rdata << lsh) |
               (rt & ((32'hFFFF_FFFF >> sh) >> 8));
      size == SZ_LWR:
        data = (rdata >> sh) |
               (rt & ~(32'hFFFF_FFFF >> sh));
      default:
        data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_load_unit.sv
// MEM-stage load unit: SRAM read issue, response formatting
// and a held writeback slot with valid/ready handshake.
module mem_load_unit
  import mem_load_unit_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_mode,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_rt,
  input  logic [4:0]  req_dest,
  input  logic        flush,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_wen,
  output logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_rdata,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_dest,
  output logic        wb_adel,
  output logic [31:0] wb_badvaddr
);

  state_t      state;
  state_t      state_nx;
  ld_ctx_t     ctx;
  logic [2:0]  size;
  logic        accept;
  logic        misal;
  logic [31:0] fmt;
  logic        unused_mode4;

  assign unused_mode4 = req_mode[4];
  assign size  = req_mode[MODE_SIZE_HI:MODE_SIZE_LO];
  assign misal = misaligned(size, req_addr[1:0]);

  assign req_ready = !flush &&
                     (state == ST_IDLE ||
                      (state == ST_RESP && wb_ready));
  assign accept = req_valid && req_ready &&
                  req_mode[MODE_LOAD];

  assign data_sram_en   = accept && !misal;
  assign data_sram_wen  = 4'b0000;
  assign data_sram_addr = {req_addr[31:2], 2'b00};
  assign wb_valid       = (state == ST_RESP);

  load_align u_align (
    .size  (ctx.size),
    .sext  (ctx.sext),
    .addr  (ctx.off),
    .rdata (data_sram_rdata),
    .rt    (ctx.rt),
    .data  (fmt)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:
        if (accept)
          state_nx = misal ? ST_RESP : ST_WAIT;
      ST_WAIT:
        state_nx = flush ? ST_IDLE : ST_RESP;
      ST_RESP:
        if (flush)
          state_nx = ST_IDLE;
        else if (accept)
          state_nx = misal ? ST_RESP : ST_WAIT;
        else if (wb_ready)
          state_nx = ST_IDLE;
      default:
        state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ctx         <= '0;
      wb_data     <= '0;
      wb_dest     <= '0;
      wb_adel     <= 1'b0;
      wb_badvaddr <= '0;
    end else if (accept) begin
      ctx.size    <= size;
      ctx.sext    <= req_mode[MODE_SEXT];
      ctx.off     <= req_addr[1:0];
      ctx.rt      <= req_rt;
      wb_dest     <= req_dest;
      wb_adel     <= misal;
      wb_badvaddr <= misal ? req_addr : 32'h0;
      if (misal)
        wb_data <= '0;
    end else if (state == ST_WAIT && !flush) begin
      wb_data <= fmt;
    end
  end

endmodule
